// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared state type and helpers for the single-input gate BIST engine
// Contents: state_t (IDLE/RUN/DONE), expected_y(), idx_w() for vec_idx width, STEP_W
package gate_bist_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int STEP_W = 8;
    function automatic logic expected_y(input logic a, input logic invert);
        return a ^ invert;
    endfunction
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: handshake and gate-drive bundle between the BIST engine and its environment
// master (engine): in start, dut_y; out dut_a, busy, done, pass, err_cnt[ERR_W], vec_idx[IDX_W]
// slave (environment): mirror of master
interface gate_bist_ctrl_if #(
    parameter int ERR_W = 4,
    parameter int IDX_W = gate_bist_pkg::idx_w(4)
);
    logic start, dut_a, dut_y, busy, done, pass;
    logic [ERR_W-1:0] err_cnt;
    logic [IDX_W-1:0] vec_idx;
    modport master (input start, dut_y, output dut_a, busy, done, pass, err_cnt, vec_idx);
    modport slave (output start, dut_y, input dut_a, busy, done, pass, err_cnt, vec_idx);
endinterface

// File: rtl/bist_step_timer.sv
// bist_step_timer: counts the hold cycles of one vector and flags the sample cycle
// Ports: clk, rst_n (async active-low), clear (restart at 0), enable (count), last_step (count == STEP_CYCLES-1)
module bist_step_timer
    import gate_bist_pkg::*;
#(
    parameter int STEP_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last_step
);
    logic [STEP_W-1:0] step_cnt;
    assign last_step = step_cnt == STEP_W'(STEP_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) step_cnt <= '0;
        else if (clear) step_cnt <= '0;
        else if (enable) step_cnt <= last_step ? '0 : step_cnt + 1'b1;
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: drives a single-input gate with 0,1,0,1... vectors and counts response mismatches
// Ports: clk, rst_n (async active-low), bus (gate_bist_ctrl_if.master: start, dut_y in;
//        dut_a, busy, done, pass, err_cnt, vec_idx out)
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int STEP_CYCLES   = 10,
    parameter int NUM_VECTORS   = 4,
    parameter bit EXPECT_INVERT = 1,
    parameter int ERR_W         = 4
) (
    input logic clk,
    input logic rst_n,
    gate_bist_ctrl_if.master bus
);
    localparam int IDX_W = idx_w(NUM_VECTORS);
    localparam logic [IDX_W-1:0] LAST_VEC = IDX_W'(NUM_VECTORS - 1);
    state_t state, state_nxt;
    logic [IDX_W-1:0] vec_idx;
    logic [ERR_W-1:0] err_cnt, err_nxt;
    logic accept, last_step, sample, final_vec, miss;
    // start is honoured from IDLE and DONE only; a run in progress ignores it
    assign accept = bus.start && state != RUN;
    assign sample = state == RUN && last_step;
    assign final_vec = vec_idx == LAST_VEC;
    assign miss = bus.dut_y != expected_y(vec_idx[0], EXPECT_INVERT);
    // saturating increment: stop at all-ones rather than wrap
    assign err_nxt = (miss && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
    bist_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .clear(accept),
        .enable(state == RUN),
        .last_step(last_step)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = accept ? RUN : (sample && final_vec) ? DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vec_idx <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            vec_idx <= '0;
            err_cnt <= '0;
        end else if (sample) begin
            err_cnt <= err_nxt;
            if (!final_vec) vec_idx <= vec_idx + 1'b1;
        end
    // outputs decode registered state only; pass reflects the err_cnt frozen in DONE
    always_comb begin
        bus.busy    = state == RUN;
        bus.done    = state == DONE;
        bus.pass    = state == DONE && err_cnt == '0;
        bus.dut_a   = state == RUN && vec_idx[0];
        bus.err_cnt = err_cnt;
        bus.vec_idx = vec_idx;
    end
endmodule
